// File: rtl/ex_wb_stage_if.sv
// rtl/ex_wb_stage_if.sv - decode-side inputs and register bank write port of the EX/WB stage
interface ex_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              stall;
  logic [5:0]        funct;
  logic [4:0]        rd;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              regWrite;
  logic [4:0]        writeReg;
  logic [DATA_W-1:0] writeData;
  logic              illegal;
  logic [CNT_W-1:0]  retired;

  // decode stage / register bank side
  modport master (
    output in_valid, stall, funct, rd, readData1, readData2,
    input  regWrite, writeReg, writeData, illegal, retired
  );

  // execute/write-back stage side
  modport slave (
    input  in_valid, stall, funct, rd, readData1, readData2,
    output regWrite, writeReg, writeData, illegal, retired
  );
endinterface

// File: rtl/ex_wb_stage.sv
// rtl/ex_wb_stage.sv - two-register R-type execute/write-back stage with retired counter
module ex_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_wb_stage_if.slave bus
);
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic              ex_valid;
  logic [5:0]        ex_funct;
  logic [4:0]        ex_rd;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;

  logic [DATA_W-1:0] alu_result;
  logic              alu_legal;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_result;
  logic              wb_legal;

  logic [CNT_W-1:0]  retired_q;

  // EX register: capture the decoded instruction unless stalled, in which case hold it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_funct <= '0;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else if (!bus.stall) begin
      ex_valid <= bus.in_valid;
      ex_funct <= bus.funct;
      ex_rd    <= bus.rd;
      ex_a     <= bus.readData1;
      ex_b     <= bus.readData2;
    end
  end

  // ALU: R-type result from the EX register; unknown funct codes yield 0 and flag illegal
  always_comb begin
    alu_result = '0;
    alu_legal  = 1'b1;
    case (ex_funct)
      F_ADD, F_ADDU: alu_result = ex_a + ex_b;
      F_SUB, F_SUBU: alu_result = ex_a - ex_b;
      F_AND:         alu_result = ex_a & ex_b;
      F_OR:          alu_result = ex_a | ex_b;
      F_XOR:         alu_result = ex_a ^ ex_b;
      F_NOR:         alu_result = ~(ex_a | ex_b);
      F_SLT:         alu_result = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      F_SLTU:        alu_result = {{(DATA_W-1){1'b0}}, (ex_a < ex_b)};
      default: begin
        alu_result = '0;
        alu_legal  = 1'b0;
      end
    endcase
  end

  // WB register: take the EX result, or a bubble while the EX instruction is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_result <= '0;
      wb_legal  <= 1'b0;
    end else if (bus.stall) begin
      wb_valid  <= 1'b0;
    end else begin
      wb_valid  <= ex_valid;
      wb_rd     <= ex_rd;
      wb_result <= alu_result;
      wb_legal  <= alu_legal;
    end
  end

  // retired counter: every instruction leaving WB counts, including $0 writes and illegals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (wb_valid) begin
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.regWrite  = wb_valid & wb_legal & (wb_rd != 5'd0);
  assign bus.writeReg  = wb_rd;
  assign bus.writeData = wb_result;
  assign bus.illegal   = wb_valid & ~wb_legal;
  assign bus.retired   = retired_q;
endmodule

// File: tb/tb_ex_wb_stage.sv
// tb/tb_ex_wb_stage.sv - directed self-checking bench for ex_wb_stage
module tb_ex_wb_stage;
  logic clk;
  logic rst_n;

  ex_wb_stage_if #(.DATA_W(32), .CNT_W(16)) bus ();
  ex_wb_stage_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

  ex_wb_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ex_wb_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;
  int pulses;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [5:0] f, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] b);
    bus.in_valid  = v;
    bus.funct     = f;
    bus.rd        = r;
    bus.readData1 = a;
    bus.readData2 = b;
  endtask

  // one isolated instruction through the pipe, checked at WB and after it retires
  task automatic run_one(input string tag, input logic [5:0] f, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic exp_we, input logic exp_ill, input logic [31:0] exp_d);
    present(1'b1, f, r, a, b);
    tick();
    present(1'b0, 6'h0, 5'd0, 32'h0, 32'h0);
    tick();
    chk({tag, ".regWrite"}, {31'b0, bus.regWrite}, {31'b0, exp_we});
    chk({tag, ".illegal"}, {31'b0, bus.illegal}, {31'b0, exp_ill});
    chk({tag, ".writeData"}, bus.writeData, exp_d);
    if (exp_we) chk({tag, ".writeReg"}, {27'b0, bus.writeReg}, {27'b0, r});
    chk({tag, ".retired_pre"}, {16'b0, bus.retired}, exp_ret);
    tick();
    exp_ret++;
    chk({tag, ".retired"}, {16'b0, bus.retired}, exp_ret);
    chk({tag, ".regWrite_off"}, {31'b0, bus.regWrite}, 32'd0);
    chk({tag, ".illegal_off"}, {31'b0, bus.illegal}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    present(1'b0, 6'h0, 5'd0, 32'h0, 32'h0);
    bus4.in_valid  = 1'b0;
    bus4.stall     = 1'b0;
    bus4.funct     = 6'h20;
    bus4.rd        = 5'd1;
    bus4.readData1 = 32'd1;
    bus4.readData2 = 32'd1;

    repeat (2) tick();
    chk("rst.regWrite", {31'b0, bus.regWrite}, 32'd0);
    chk("rst.writeReg", {27'b0, bus.writeReg}, 32'd0);
    chk("rst.writeData", bus.writeData, 32'd0);
    chk("rst.illegal", {31'b0, bus.illegal}, 32'd0);
    chk("rst.retired", {16'b0, bus.retired}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle.regWrite", {31'b0, bus.regWrite}, 32'd0);

    run_one("add",      6'h20, 5'd3,  32'd5,         32'd7,         1'b1, 1'b0, 32'd12);
    run_one("sub_wrap", 6'h22, 5'd4,  32'd0,         32'd1,         1'b1, 1'b0, 32'hFFFF_FFFF);
    run_one("add_wrap", 6'h21, 5'd5,  32'hFFFF_FFFF, 32'd1,         1'b1, 1'b0, 32'd0);
    run_one("slt",      6'h2A, 5'd6,  32'hFFFF_FFFF, 32'd1,         1'b1, 1'b0, 32'd1);
    run_one("sltu",     6'h2B, 5'd7,  32'hFFFF_FFFF, 32'd1,         1'b1, 1'b0, 32'd0);
    run_one("sltu_t",   6'h2B, 5'd8,  32'd1,         32'hFFFF_FFFF, 1'b1, 1'b0, 32'd1);
    run_one("nor",      6'h27, 5'd9,  32'd0,         32'd0,         1'b1, 1'b0, 32'hFFFF_FFFF);
    run_one("and",      6'h24, 5'd10, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 1'b0, 32'h00F0_1200);
    run_one("or",       6'h25, 5'd11, 32'hF000_0001, 32'h0000_0F00, 1'b1, 1'b0, 32'hF000_0F01);
    run_one("xor",      6'h26, 5'd12, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 1'b0, 32'h5555_5555);
    run_one("subu",     6'h23, 5'd13, 32'd100,       32'd58,        1'b1, 1'b0, 32'd42);
    run_one("rd0",      6'h20, 5'd0,  32'd2,         32'd3,         1'b0, 1'b0, 32'd5);
    run_one("illegal",  6'h3F, 5'd14, 32'd2,         32'd3,         1'b0, 1'b1, 32'd0);

    // stall: A then B back to back, B held in EX for two stalled edges
    pulses = 0;
    present(1'b1, 6'h20, 5'd1, 32'd1, 32'd1);
    tick();
    present(1'b1, 6'h20, 5'd2, 32'd2, 32'd3);
    tick();
    chk("stall.A.regWrite", {31'b0, bus.regWrite}, 32'd1);
    chk("stall.A.writeReg", {27'b0, bus.writeReg}, 32'd1);
    chk("stall.A.writeData", bus.writeData, 32'd2);
    if (bus.regWrite) pulses++;
    bus.stall = 1'b1;
    present(1'b1, 6'h20, 5'd7, 32'd9, 32'd9);
    tick();
    chk("stall.bubble1", {31'b0, bus.regWrite}, 32'd0);
    if (bus.regWrite) pulses++;
    tick();
    chk("stall.bubble2", {31'b0, bus.regWrite}, 32'd0);
    if (bus.regWrite) pulses++;
    bus.stall = 1'b0;
    present(1'b0, 6'h0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("stall.B.regWrite", {31'b0, bus.regWrite}, 32'd1);
    chk("stall.B.writeReg", {27'b0, bus.writeReg}, 32'd2);
    chk("stall.B.writeData", bus.writeData, 32'd5);
    if (bus.regWrite) pulses++;
    tick();
    chk("stall.after", {31'b0, bus.regWrite}, 32'd0);
    if (bus.regWrite) pulses++;
    exp_ret += 2;
    chk("stall.pulses", pulses, 32'd2);
    chk("stall.retired", {16'b0, bus.retired}, exp_ret);

    // asynchronous reset while a write is on the bank port and another is in EX
    present(1'b1, 6'h20, 5'd4, 32'd10, 32'd20);
    tick();
    present(1'b1, 6'h20, 5'd5, 32'd30, 32'd40);
    tick();
    present(1'b0, 6'h0, 5'd0, 32'h0, 32'h0);
    chk("arst.pre_regWrite", {31'b0, bus.regWrite}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.regWrite", {31'b0, bus.regWrite}, 32'd0);
    chk("arst.writeReg", {27'b0, bus.writeReg}, 32'd0);
    chk("arst.writeData", bus.writeData, 32'd0);
    chk("arst.illegal", {31'b0, bus.illegal}, 32'd0);
    chk("arst.retired", {16'b0, bus.retired}, 32'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (3) begin
      tick();
      if (bus.regWrite) pulses++;
    end
    chk("arst.no_write", pulses, 32'd0);
    chk("arst.retired_after", {16'b0, bus.retired}, 32'd0);

    // 4-bit counter wraps after 16 retirements
    bus4.in_valid = 1'b1;
    repeat (17) tick();
    bus4.in_valid = 1'b0;
    repeat (2) tick();
    chk("wrap.retired", {28'b0, bus4.retired}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
